// File: rtl/instr_cache_fetch.sv
// ---------------------------------------------------------------------------------------------
// instr_cache_fetch
//   Instruction-fetch stage: direct-mapped, read-only instruction cache in front of
//   instruction memory. Returns the 32-bit word at PC on a hit and refills a whole
//   128-bit block on a miss, stalling upstream with BUSYWAIT while the refill runs.
//
// Ports
//   CLK           clock, all state updates on posedge
//   RESET         synchronous, active-high reset
//   PC            fetch byte address
//   INSTRUCTION   registered fetched instruction word
//   BUSYWAIT      1 = fetch not ready, upstream must hold PC
//   mem_read      refill request to instruction memory
//   mem_address   block address {tag,index} of the refill
//   mem_readdata  refill block, word0 in [31:0] ... word3 in [127:96]
//   mem_busywait  1 = memory busy; data valid in the cycle it drops with mem_read=1
// ---------------------------------------------------------------------------------------------
module instr_cache_fetch #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    PC,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           mem_read,
    output logic [TAG_BITS+INDEX_BITS-1:0] mem_address,
    input  logic [127:0]                   mem_readdata,
    input  logic                           mem_busywait
);

    localparam int unsigned BLOCK_WORDS = 4;
    localparam int unsigned BLOCK_BITS  = 32 * BLOCK_WORDS;
    localparam int unsigned NUM_BLOCKS  = 1 << INDEX_BITS;
    localparam int unsigned ADDR_BITS   = TAG_BITS + INDEX_BITS;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_READ = 2'd1;
    localparam logic [1:0] UPDATE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [31:0]           instr_q, instr_d;
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
    logic [TAG_BITS-1:0]   tag_d  [NUM_BLOCKS];
    logic [BLOCK_BITS-1:0] data_q [NUM_BLOCKS];
    logic [BLOCK_BITS-1:0] data_d [NUM_BLOCKS];

    logic [1:0]            word_sel;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  no_fetch;
    logic                  hit;

    assign word_sel   = PC[3:2];
    assign pc_index   = PC[INDEX_BITS+3:4];
    assign pc_tag     = PC[ADDR_BITS+3:INDEX_BITS+4];
    // The post-reset PC value (-4) is not a real fetch: no miss, output held.
    assign no_fetch   = (PC == 32'hFFFF_FFFC);
    assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    // Refill always targets the latched miss address, never the live PC.
    assign fill_index = addr_q[INDEX_BITS-1:0];
    assign fill_tag   = addr_q[ADDR_BITS-1:INDEX_BITS];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        BUSYWAIT = 1'b0;
        mem_read = 1'b0;

        case (state_q)
            IDLE: begin
                if (!no_fetch) begin
                    if (hit) begin
                        instr_d = data_q[pc_index][{word_sel, 5'b0} +: 32];
                    end else begin
                        BUSYWAIT = 1'b1;
                        addr_d   = {pc_tag, pc_index};
                        state_d  = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                BUSYWAIT = 1'b1;
                if (!mem_busywait) begin
                    valid_d[fill_index] = 1'b1;
                    tag_d[fill_index]   = fill_tag;
                    data_d[fill_index]  = mem_readdata;
                    state_d             = UPDATE;
                end
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arrays are only written outside reset, so a reset coinciding with the
    // memory handshake leaves the target block untouched and invalid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign mem_address = addr_q;

endmodule

// File: tb/tb_instr_cache_fetch.sv
module tb_instr_cache_fetch;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int n_cmp = 0;
    int n_bad = 0;

    instr_cache_fetch #(
        .INDEX_BITS (3),
        .TAG_BITS   (3)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: every word encodes its block address and word number.
    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
        return {16'hCAFE, 2'b00, blk, 6'b000000, w};
    endfunction

    int lat = 1;
    int mem_cnt = 0;
    int rd_cycles = 0;
    logic [5:0] fill_q [$];
    logic [31:0] exp_q [$];

    assign mem_busywait = mem_read && ((mem_cnt + 1) < lat);
    assign mem_readdata = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                           mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};

    always @(posedge CLK) begin
        mem_cnt <= mem_read ? mem_cnt + 1 : 0;
        if (mem_read) rd_cycles <= rd_cycles + 1;
        if (mem_read && !mem_busywait) fill_q.push_back(mem_address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives PC, counts stall cycles, then checks the fetched word.
    task automatic fetch(input logic [31:0] pc, input int l, input int exp_busy,
                         input int exp_fills, input logic [5:0] exp_addr);
        int n;
        int f0;
        int r0;
        logic [31:0] want;
        f0 = fill_q.size();
        r0 = rd_cycles;
        lat = l;
        PC = pc;
        exp_q.push_back(mem_word(pc[9:4], pc[3:2]));
        #1;
        n = 0;
        while (BUSYWAIT && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("busy_cycles", n, exp_busy);
        @(negedge CLK);
        want = exp_q.pop_front();
        chk("instr", INSTRUCTION, want);
        chk("fills", fill_q.size() - f0, exp_fills);
        if (exp_fills > 0 && fill_q.size() > 0) chk("fill_addr", {26'd0, fill_q[$]}, {26'd0, exp_addr});
        chk("rd_cycles", rd_cycles - r0, exp_fills * l);
    endtask

    typedef struct {
        logic [31:0] pc;
        int          l;
        int          busy;
        int          fills;
        logic [5:0]  addr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        int f0;
        int r0;

        vecs[0]  = '{32'h000, 5, 7, 1, 6'h00};  // cold miss
        vecs[1]  = '{32'h004, 5, 0, 0, 6'h00};  // hits in block
        vecs[2]  = '{32'h008, 5, 0, 0, 6'h00};
        vecs[3]  = '{32'h00C, 5, 0, 0, 6'h00};
        vecs[4]  = '{32'h080, 3, 5, 1, 6'h08};  // conflict miss, tag 1 index 0
        vecs[5]  = '{32'h084, 3, 0, 0, 6'h00};
        vecs[6]  = '{32'h000, 2, 4, 1, 6'h00};  // tag 0 replaced, misses again
        vecs[7]  = '{32'h034, 1, 3, 1, 6'h03};  // minimum latency
        vecs[8]  = '{32'h3FC, 4, 6, 1, 6'h3F};  // top block
        vecs[9]  = '{32'h7FD, 4, 0, 0, 6'h00};  // upper and byte bits ignored
        vecs[10] = '{32'h038, 1, 0, 0, 6'h00};
        vecs[11] = '{32'h00E, 1, 0, 0, 6'h00};

        RESET = 1'b1;
        PC = 32'hFFFF_FFFC;
        repeat (2) @(negedge CLK);
        chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_instr", INSTRUCTION, 32'd0);
        chk("rst_mem_addr", {26'd0, mem_address}, 32'd0);
        RESET = 1'b0;

        // No-fetch PC after reset starts nothing.
        r0 = rd_cycles;
        repeat (3) @(negedge CLK);
        chk("nofetch_busy", {31'd0, BUSYWAIT}, 32'd0);
        chk("nofetch_rd", rd_cycles - r0, 0);

        foreach (vecs[i]) fetch(vecs[i].pc, vecs[i].l, vecs[i].busy, vecs[i].fills, vecs[i].addr);

        // No-fetch PC would hit block 0x3F word 3, but INSTRUCTION must hold.
        r0 = rd_cycles;
        PC = 32'hFFFF_FFFC;
        repeat (3) @(negedge CLK);
        chk("hold_busy", {31'd0, BUSYWAIT}, 32'd0);
        chk("hold_instr", INSTRUCTION, mem_word(6'h00, 2'd3));
        chk("hold_rd", rd_cycles - r0, 0);

        // Reset in the third MEM_READ cycle abandons the refill.
        lat = 8;
        PC = 32'h10;
        repeat (3) @(negedge CLK);
        chk("mr_before_rst", {31'd0, mem_read}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("mr_after_rst", {31'd0, mem_read}, 32'd0);
        chk("addr_after_rst", {26'd0, mem_address}, 32'd0);
        chk("instr_after_rst", INSTRUCTION, 32'd0);
        PC = 32'hFFFF_FFFC;
        @(negedge CLK);
        fetch(32'h10, 2, 4, 1, 6'h01);
        fetch(32'h00, 1, 3, 1, 6'h00);   // reset invalidated block 0 too

        // Reset in the same cycle mem_busywait falls: block must not be written.
        lat = 3;
        PC = 32'h50;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        PC = 32'hFFFF_FFFC;
        @(negedge CLK);
        fetch(32'h50, 2, 4, 1, 6'h05);

        // PC moves during the stall: block 2 still filled, then block 4 refilled back-to-back.
        lat = 4;
        f0 = fill_q.size();
        PC = 32'h20;
        #1;
        n = 0;
        while (BUSYWAIT && n < 100) begin
            n++;
            @(negedge CLK);
            if (n == 1) begin
                PC = 32'h40;
                exp_q.push_back(mem_word(6'h04, 2'd0));
            end
            if (n == 2) chk("stall_mem_addr", {26'd0, mem_address}, 32'd2);
        end
        chk("b2b_busy_cycles", n, 12);
        @(negedge CLK);
        if (exp_q.size() > 0) chk("b2b_instr", INSTRUCTION, exp_q.pop_front());
        chk("b2b_fills", fill_q.size() - f0, 2);
        if (fill_q.size() >= f0 + 2) begin
            chk("b2b_fill0", {26'd0, fill_q[f0]}, 32'd2);
            chk("b2b_fill1", {26'd0, fill_q[f0+1]}, 32'd4);
        end
        fetch(32'h20, 1, 0, 0, 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
